// File: rtl/pad_row_sched_pkg.sv
// Shared constants and state encoding for the padded-frame row scheduler.
package pad_row_sched_pkg;
  localparam int IMG_H  = 416;
  localparam int PAD    = 1;
  localparam int ROW_AW = 9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_SHIFT = 3'd2,
    S_WIN   = 3'd3,
    S_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/pad_row_sched_if.sv
// Handshake bundle between scheduler, frame memory, padding datapath and conv engine.
interface pad_row_sched_if #(parameter int ROW_AW = 9);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              rd_req;
  logic [ROW_AW-1:0] rd_row;
  logic              rd_ack;
  logic              shift_en;
  logic              zero_row;
  logic              win_valid;
  logic [ROW_AW-1:0] win_row;
  logic              win_ready;

  modport master (
    output start, abort, rd_ack, win_ready,
    input  busy, done, rd_req, rd_row, shift_en, zero_row, win_valid, win_row
  );
  modport slave (
    input  start, abort, rd_ack, win_ready,
    output busy, done, rd_req, rd_row, shift_en, zero_row, win_valid, win_row
  );
endinterface

// File: rtl/pad_row_sched_pad_row_cnt.sv
// Padded-row counter p (0..IMG_H+1) with the boundary compares the scheduler branches on.
module pad_row_cnt #(
  parameter int IMG_H  = 416,
  parameter int ROW_AW = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ROW_AW-1:0] o_p,
  output logic              o_first,
  output logic              o_last,
  output logic              o_next_last,
  output logic              o_ge2
);
  logic [ROW_AW-1:0] r_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_p <= '0;
    else if (i_clr) r_p <= '0;
    else if (i_inc) r_p <= r_p + ROW_AW'(1);
  end

  assign o_p         = r_p;
  assign o_first     = (r_p == '0);
  assign o_last      = (r_p == ROW_AW'(IMG_H + 1));
  assign o_next_last = (r_p == ROW_AW'(IMG_H));
  assign o_ge2       = (r_p >= ROW_AW'(2));
endmodule

// File: rtl/pad_row_sched.sv
// Sequences one zero-padded frame: fetch/zero row, shift, then hand the 3-row window to the conv engine.
// Optional SCHED_STALL_CNT_EN adds a saturating stall counter output.
module pad_row_sched #(
  parameter int IMG_H  = pad_row_sched_pkg::IMG_H,
  parameter int ROW_AW = pad_row_sched_pkg::ROW_AW
) (
  input  logic            clk,
  input  logic            reset,
  pad_row_sched_if.slave  bus
`ifdef SCHED_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);
  import pad_row_sched_pkg::*;

  state_e            r_state, w_nxt;
  logic              w_clr, w_inc;
  logic [ROW_AW-1:0] w_p;
  logic              w_first, w_last, w_next_last, w_ge2;

  pad_row_cnt #(.IMG_H(IMG_H), .ROW_AW(ROW_AW)) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_clr),
    .i_inc       (w_inc),
    .o_p         (w_p),
    .o_first     (w_first),
    .o_last      (w_last),
    .o_next_last (w_next_last),
    .o_ge2       (w_ge2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    w_clr = 1'b0;
    w_inc = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.start) begin
                 w_nxt = S_SHIFT;
                 w_clr = 1'b1;
               end
      S_REQ:   if (bus.rd_ack) w_nxt = S_SHIFT;
      S_SHIFT: if (w_ge2) w_nxt = S_WIN;
               else begin
                 w_inc = 1'b1;
                 w_nxt = S_REQ;
               end
      // The bottom padding row needs no fetch, so go straight to its shift.
      S_WIN:   if (bus.win_ready) begin
                 if (w_last) w_nxt = S_DONE;
                 else begin
                   w_inc = 1'b1;
                   w_nxt = w_next_last ? S_SHIFT : S_REQ;
                 end
               end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (bus.abort) begin
      w_nxt = S_IDLE;
      w_clr = 1'b0;
      w_inc = 1'b0;
    end
  end

  // Row indices are gated so every output reads zero outside its owning state.
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rd_req    = (r_state == S_REQ);
  assign bus.rd_row    = (r_state == S_REQ) ? (w_p - ROW_AW'(1)) : '0;
  assign bus.shift_en  = (r_state == S_SHIFT);
  assign bus.zero_row  = (r_state == S_SHIFT) && (w_first || w_last);
  assign bus.win_valid = (r_state == S_WIN);
  assign bus.win_row   = (r_state == S_WIN) ? (w_p - ROW_AW'(2)) : '0;
  assign bus.done      = (r_state == S_DONE);

`ifdef SCHED_STALL_CNT_EN
  logic [31:0] r_stall;
  logic        w_stall;

  assign w_stall = ((r_state == S_REQ) && !bus.rd_ack) ||
                   ((r_state == S_WIN) && !bus.win_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          r_stall <= '0;
    else if (w_clr)                      r_stall <= '0;
    else if (w_stall && (r_stall != '1)) r_stall <= r_stall + 32'd1;
  end

  assign stall_cnt = r_stall;
`endif
endmodule

// File: tb/tb_pad_row_sched.sv
// Directed + randomized bench for pad_row_sched at IMG_H=4 against an event-list reference model.
module tb_pad_row_sched;
  localparam int H  = 4;
  localparam int AW = 9;

  typedef struct {
    int kind;  // 0 read, 1 shift (idx = zero flag), 2 window, 3 done
    int idx;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pad_row_sched_if #(.ROW_AW(AW)) bus();
`ifdef SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  pad_row_sched #(.IMG_H(H), .ROW_AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef SCHED_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int rd_dly [H];
  int win_dly[H];
  int abort_row = -1;
  bit noise = 1'b0;

  function automatic logic [23:0] pk(int b, int rq, int rr, int sh, int z, int wv, int wr, int d);
    logic [AW-1:0] a, c;
    a = rr[AW-1:0];
    c = wr[AW-1:0];
    return {b[0], rq[0], a, sh[0], z[0], wv[0], c, d[0]};
  endfunction

  function automatic logic [23:0] obs();
    return {bus.busy, bus.rd_req, bus.rd_row, bus.shift_en, bus.zero_row,
            bus.win_valid, bus.win_row, bus.done};
  endfunction

  task automatic chk(input string tag, input logic [23:0] o, input logic [23:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // One frame: expected event order comes straight from the padded-row rules.
  task automatic run_frame(input int exp_cyc);
    ev_t q[$];
    int k = 0, cyc = 0, d = 0, stalls = 0;
    bit fin = 1'b0, adv;
    logic [23:0] e;
    for (int p = 0; p <= H + 1; p++) begin
      if (p >= 1 && p <= H) q.push_back('{0, p - 1});
      q.push_back('{1, (p == 0 || p == H + 1) ? 1 : 0});
      if (p >= 2) q.push_back('{2, p - 2});
    end
    q.push_back('{3, 0});

    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b0; bus.rd_ack = 1'b0; bus.win_ready = 1'b0;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      case (q[k].kind)
        0:       e = pk(1, 1, q[k].idx, 0, 0, 0, 0, 0);
        1:       e = pk(1, 0, 0, 1, q[k].idx, 0, 0, 0);
        2:       e = pk(1, 0, 0, 0, 0, 1, q[k].idx, 0);
        default: e = pk(1, 0, 0, 0, 0, 0, 0, 1);
      endcase
      chk($sformatf("ev%0d_kind%0d_cyc%0d", k, q[k].kind, cyc), obs(), e);
      bus.start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.rd_ack    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.win_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      adv = 1'b0;
      case (q[k].kind)
        0: begin
          bus.rd_ack = 1'b0;
          if (d >= rd_dly[q[k].idx]) begin bus.rd_ack = 1'b1; adv = 1'b1; end
          else stalls++;
        end
        1: adv = 1'b1;
        2: begin
          if (q[k].idx == abort_row) begin
            bus.abort = 1'b1; bus.win_ready = 1'b1; bus.start = 1'b0; fin = 1'b1;
          end else begin
            bus.win_ready = 1'b0;
            if (d >= win_dly[q[k].idx]) begin bus.win_ready = 1'b1; adv = 1'b1; end
            else stalls++;
          end
        end
        default: begin
          fin = 1'b1;
          bus.start = 1'b0;
          if (exp_cyc > 0) chk32("done_latency", cyc, exp_cyc);
`ifdef SCHED_STALL_CNT_EN
          chk32("stall_cnt_at_done", stall_cnt, stalls);
`endif
        end
      endcase
      if (adv) begin k++; d = 0; end
      else d++;
    end
    checks++;
    assert (fin) else begin
      errors++;
      $error("FAIL frame_timeout observed=%0d cycles expected=done", cyc);
    end
    @(negedge clk);
    bus.abort = 1'b0; bus.start = 1'b0; bus.rd_ack = 1'b0; bus.win_ready = 1'b0;
    chk("idle_after_frame", obs(), '0);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.rd_ack = 1'b0; bus.win_ready = 1'b0;
    foreach (rd_dly[i]) begin rd_dly[i] = 0; win_dly[i] = 0; end
    #1 chk("reset_outputs", obs(), '0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset_release", obs(), '0);

    // Best case: 15-cycle frame with zero rows on first/last shift
    run_frame(15);

    // Row 2 read stalled 3 cycles, window 1 stalled 5 cycles
    rd_dly[2] = 3; win_dly[1] = 5;
    run_frame(23);
    rd_dly[2] = 0; win_dly[1] = 0;

    // Abort while window 2 is pending, then a clean replay
    abort_row = 2;
    run_frame(0);
    abort_row = -1;
    run_frame(15);

    // Async reset while a read request is outstanding
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("shift_before_reset", obs(), pk(1, 0, 0, 1, 1, 0, 0, 0));
    @(negedge clk);
    chk("req_before_reset", obs(), pk(1, 1, 0, 0, 0, 0, 0, 0));
    #2 reset = 1'b0;
    #1 chk("async_reset_in_req", obs(), '0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("idle_after_midframe_reset", obs(), '0);

    // Random delays with start/ack/ready noise outside their owning states
    noise = 1'b1;
    for (int f = 0; f < 5; f++) begin
      foreach (rd_dly[i]) begin
        rd_dly[i]  = $urandom_range(0, 3);
        win_dly[i] = $urandom_range(0, 3);
      end
      run_frame(0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
